f1_start_sequencer: RTL
=======================

Name: f1_start_sequencer

Overview:
- Full F1 start-light controller: owns the lights output, the tick timebase, the random hold delay and the driver reaction timer.
- Sequences the 8 lights on one at a time at a fixed step period, holds all-on for a pseudo-random number of steps, then blanks them.
- Measures the ticks elapsed until the driver's `react` input, and flags false starts.
- Sits between the top-level button/switch inputs and the light bar / 7-seg display.

Parameters:
- WIDTH, 16, width of tick divider count and `n` port.
- STEP_TICKS, 1000, ticks per light step; also one unit of hold delay.
- SEED, 7'h01, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- trigger  input  1  start request, level-sampled; honoured only in IDLE.
- react  input  1  driver button, level-sampled.
- n  input  WIDTH  tick divider: one tick every n+1 clk cycles.
- data_out  output  8  light bar.
- reaction_time  output  16  ticks from lights-out to react.
- valid  output  1  one-cycle pulse when reaction_time is updated.
- false_start  output  1  one-cycle pulse on react before lights-out.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, async), all outputs registered:
  - data_out=0, reaction_time=0, valid=0, false_start=0, busy=0.
  - State IDLE, LFSR=SEED, step and tick counters=0.
- Tick divider:
  - Down-counter loaded with n; tick is a one-cycle pulse when the count is 0, then it reloads n.
  - Held at n in IDLE, so the first tick comes n+1 cycles after leaving IDLE.
  - n=0 gives a tick every cycle.
  - n is sampled only at reload.
- LFSR:
  - 7-bit Fibonacci, x^7+x^6+1.
  - Shifts every clk cycle in every state; never reaches 0.
- IDLE:
  - trigger=1 → LIGHTS next cycle, data_out=8'h01, step=0.
- LIGHTS:
  - On each tick, step++.
  - On a tick with step==STEP_TICKS-1: step=0.
    - If data_out==8'hFF: go to HOLD, and latch hold=LFSR (1..127) on that same cycle.
    - Else: data_out={data_out[6:0],1'b1}.
  - Light sequence: 01,03,07,0F,1F,3F,7F,FF.
- HOLD:
  - data_out stays FF. Step counting is identical to LIGHTS.
  - Each completed step decrements hold.
  - On the step completion with hold==1: data_out=0, go to RACE, race counter=0.
- RACE:
  - Each tick increments the race counter, saturating at 16'hFFFF.
  - react=1 → reaction_time=counter, valid=1 for one cycle, go to IDLE.
  - react and tick in the same cycle: the captured value excludes that tick.
- False start:
  - react=1 in LIGHTS or HOLD → data_out=0, false_start=1 for one cycle, go to IDLE.
  - reaction_time is unchanged.
  - react has priority over a simultaneous step completion.
- In IDLE:
  - react is ignored.
  - trigger held high restarts a new sequence on the cycle after returning to IDLE.
  - trigger is ignored in all other states.
- Reset asserted mid-sequence: immediate return to reset values, with no valid or false_start pulse.
- busy is registered with the state; it rises in the same cycle data_out becomes 01.

Decomposition:
- Package f1_pkg holds:
  - State enum: IDLE, LIGHTS, HOLD, RACE.
  - Constants: LIGHTS_FIRST=8'h01, LIGHTS_ALL=8'hFF, LFSR tap positions.
- Sub-module lfsr7:
  - Ports: clk, rst, seed parameter, 7-bit out.
  - Active-low async reset; free-running.
- Tick divider, step counter, hold counter and FSM stay in the top module.

Test Plan:
- Common setup: n=1, STEP_TICKS=2, so one step = 4 cycles.
- Normal run: trigger pulse.
  - data_out walks 01→03→…→FF, one change every 4 cycles.
  - FF persists 4×(latched LFSR) cycles, then 00.
  - react 10 cycles after lights-out → reaction_time=5, valid single pulse.
- False start: react 2 cycles after data_out=07.
  - Next cycle: data_out=00, false_start pulse, busy=0, reaction_time unchanged.
- Saturation: n=0, no react for 70000 cycles in RACE → reaction_time=16'hFFFF on react.
- Trigger ignored while busy: trigger pulses during LIGHTS/HOLD → sequence timing identical to the normal run.
- Async reset:
  - rst low mid-HOLD → outputs zero without a clock edge.
  - After release, the first trigger restarts at 01 with LFSR=SEED.
- LFSR: 127 consecutive reads → all values 1..127 seen exactly once, 0 never seen.

Source files
------------

// File: rtl/f1_start_sequencer_pkg.sv
// Shared state encoding and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LIGHTS,
    HOLD,
    RACE
  } state_t;

  localparam logic [7:0] LIGHTS_FIRST = 8'h01;
  localparam logic [7:0] LIGHTS_ALL   = 8'hFF;

  // Zero-based tap bits for the x^7 + x^6 + 1 Fibonacci LFSR
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 5;

endpackage

// File: rtl/f1_start_sequencer_lfsr7.sv
// Free-running 7-bit maximal-length LFSR; its value seeds the random all-on hold.
module lfsr7
  import f1_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else begin
      value <= {value[5:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/f1_start_sequencer.sv
// F1 start-light controller: light sequencing, random hold, reaction timing and
// false-start detection on a shared tick timebase.
module f1_start_sequencer
  import f1_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter int         STEP_TICKS = 1000,
  parameter logic [6:0] SEED       = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             react,
  input  logic [WIDTH-1:0] n,
  output logic [7:0]       data_out,
  output logic [15:0]      reaction_time,
  output logic             valid,
  output logic             false_start,
  output logic             busy
);

  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   tick_cnt;
  logic [STEP_W-1:0]  step;
  logic [6:0]         hold;
  logic [15:0]        race_cnt;
  logic [6:0]         lfsr;
  logic               tick;
  logic               step_done;
  logic [7:0]         data_next;
  logic [15:0]        rt_next;
  logic               valid_next;
  logic               fs_next;

  lfsr7 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  assign tick      = (state != IDLE) && (tick_cnt == '0);
  assign step_done = tick && (step == STEP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // react always wins over a step completion in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = LIGHTS;
      LIGHTS: begin
        if (react)                                     state_next = IDLE;
        else if (step_done && data_out == LIGHTS_ALL)  state_next = HOLD;
      end
      HOLD: begin
        if (react)                                     state_next = IDLE;
        else if (step_done && hold == 7'd1)            state_next = RACE;
      end
      RACE:    if (react) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next  = data_out;
    rt_next    = reaction_time;
    valid_next = 1'b0;
    fs_next    = 1'b0;
    case (state)
      IDLE: if (trigger) data_next = LIGHTS_FIRST;
      LIGHTS: begin
        if (react) begin
          data_next = 8'h00;
          fs_next   = 1'b1;
        end else if (step_done && data_out != LIGHTS_ALL) begin
          data_next = {data_out[6:0], 1'b1};
        end
      end
      HOLD: begin
        if (react) begin
          data_next = 8'h00;
          fs_next   = 1'b1;
        end else if (step_done && hold == 7'd1) begin
          data_next = 8'h00;
        end
      end
      RACE: begin
        if (react) begin
          rt_next    = race_cnt;
          valid_next = 1'b1;
        end
      end
      default: data_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out      <= 8'h00;
      reaction_time <= 16'h0000;
      valid         <= 1'b0;
      false_start   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_out      <= data_next;
      reaction_time <= rt_next;
      valid         <= valid_next;
      false_start   <= fs_next;
      busy          <= (state_next != IDLE);
    end
  end

  // Divider sits at n while idle so the first tick lands n+1 cycles after start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      step     <= '0;
      hold     <= 7'd0;
      race_cnt <= 16'h0000;
    end else begin
      if (state == IDLE || tick_cnt == '0) tick_cnt <= n;
      else                                 tick_cnt <= tick_cnt - 1'b1;

      if (state == IDLE) begin
        step <= '0;
      end else if ((state == LIGHTS || state == HOLD) && tick) begin
        step <= step_done ? '0 : step + 1'b1;
      end

      if (state == LIGHTS && step_done && data_out == LIGHTS_ALL) begin
        hold <= lfsr;
      end else if (state == HOLD && step_done) begin
        hold <= hold - 7'd1;
      end

      if (state != RACE) begin
        race_cnt <= 16'h0000;
      end else if (tick && race_cnt != 16'hFFFF) begin
        race_cnt <= race_cnt + 16'd1;
      end
    end
  end

endmodule
